// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: arbitration modes and the
// broadcast packet layout at core-default widths.
package cdb_pkg;

    localparam int unsigned ARB_RR  = 0;
    localparam int unsigned ARB_AGE = 1;

    localparam int unsigned PKT_TAG_W     = 4;
    localparam int unsigned PKT_ROB_PTR_W = 4;

    typedef struct packed {
        logic [PKT_TAG_W-1:0]     tag;
        logic [31:0]              wdata;
        logic [PKT_ROB_PTR_W-1:0] inst_id;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_pick.sv
// Rotating first-set picker: scans req upward from start (mod N) and returns the
// first set index plus the request vector with that bit removed.
module cdb_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     req_rest
);

    always_comb begin
        int unsigned j;
        found    = 1'b0;
        idx      = '0;
        req_rest = req;
        for (int unsigned off = 0; off < N; off++) begin
            j = (32'(start) + off) % N;
            if (!found && req[j]) begin
                found       = 1'b1;
                idx         = IDX_W'(j);
                req_rest[j] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Multi-lane CDB arbiter: grants up to N_CDB execution-unit results per cycle
// (round-robin or oldest-first) and broadcasts them on registered lanes next cycle.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned N_EXU     = 4,
    parameter int unsigned N_CDB     = 2,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned ROB_PTR_W = $clog2(ROB_DEPTH),
    parameter int unsigned ARB_MODE  = ARB_RR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [ROB_PTR_W-1:0]       rob_head,
    input  logic [N_EXU-1:0]           exu_req,
    output logic [N_EXU-1:0]           exu_rdy,
    input  logic [N_EXU*TAG_W-1:0]     exu_tag,
    input  logic [N_EXU*32-1:0]        exu_wdata,
    input  logic [N_EXU*ROB_PTR_W-1:0] exu_inst_id,
    output logic [N_CDB-1:0]           cdb_wr,
    output logic [N_CDB*TAG_W-1:0]     cdb_tag,
    output logic [N_CDB*32-1:0]        cdb_wdata,
    output logic [N_CDB*ROB_PTR_W-1:0] cdb_inst_id
);

    localparam int unsigned IDX_W = $clog2(N_EXU);

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [31:0]          wdata;
        logic [ROB_PTR_W-1:0] inst_id;
    } lane_t;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_CDB-1:0] cdb_wr_q, cdb_wr_d;
    lane_t            lane_q [N_CDB];
    lane_t            lane_d [N_CDB];

    logic [N_EXU-1:0] req_eff;
    logic [N_EXU-1:0] req_left;
    logic [N_CDB-1:0] gnt_vld;
    logic [IDX_W-1:0] gnt_idx [N_CDB];

    // Reset and flush both mask requests, so nothing downstream can grant.
    assign req_eff = (rst_n && !flush) ? exu_req : '0;
    assign exu_rdy = req_eff & ~req_left;

    if (ARB_MODE == ARB_RR) begin : g_rr
        logic [N_EXU-1:0] chain [N_CDB+1];
        logic             unused_rob_head;

        assign chain[0]        = req_eff;
        assign req_left        = chain[N_CDB];
        assign unused_rob_head = ^rob_head;

        for (genvar k = 0; k < N_CDB; k++) begin : g_stage
            cdb_pick #(
                .N     (N_EXU),
                .IDX_W (IDX_W)
            ) u_pick (
                .req      (chain[k]),
                .start    (rr_ptr_q),
                .found    (gnt_vld[k]),
                .idx      (gnt_idx[k]),
                .req_rest (chain[k+1])
            );
        end
    end else begin : g_age
        logic [ROB_PTR_W-1:0] age [N_EXU];
        logic                 unused_rr_ptr;

        assign unused_rr_ptr = ^rr_ptr_q;

        always_comb begin
            logic                 found;
            logic [ROB_PTR_W-1:0] best_age;
            logic [IDX_W-1:0]     best;
            req_left = req_eff;
            gnt_vld  = '0;
            found    = 1'b0;
            best_age = '0;
            best     = '0;
            for (int unsigned i = 0; i < N_EXU; i++) begin
                age[i] = exu_inst_id[i*ROB_PTR_W +: ROB_PTR_W] - rob_head;
            end
            for (int unsigned k = 0; k < N_CDB; k++) begin
                found    = 1'b0;
                best_age = '0;
                best     = '0;
                // Strict compare keeps the lower index on equal ages.
                for (int unsigned i = 0; i < N_EXU; i++) begin
                    if (req_left[i] && (!found || age[i] < best_age)) begin
                        found    = 1'b1;
                        best_age = age[i];
                        best     = IDX_W'(i);
                    end
                end
                gnt_vld[k] = found;
                gnt_idx[k] = best;
                if (found) req_left[best] = 1'b0;
            end
        end
    end

    always_comb begin
        int unsigned sel;
        rr_ptr_d = rr_ptr_q;
        cdb_wr_d = gnt_vld;
        for (int unsigned k = 0; k < N_CDB; k++) begin
            sel       = 32'(gnt_idx[k]);
            lane_d[k] = '0;
            if (gnt_vld[k]) begin
                lane_d[k].tag     = exu_tag[sel*TAG_W +: TAG_W];
                lane_d[k].wdata   = exu_wdata[sel*32 +: 32];
                lane_d[k].inst_id = exu_inst_id[sel*ROB_PTR_W +: ROB_PTR_W];
                rr_ptr_d          = (sel == N_EXU - 1) ? '0 : IDX_W'(sel + 1);
            end
        end
        if (ARB_MODE != ARB_RR) rr_ptr_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            cdb_wr_q <= '0;
            for (int unsigned k = 0; k < N_CDB; k++) lane_q[k] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_wr_q <= cdb_wr_d;
            for (int unsigned k = 0; k < N_CDB; k++) lane_q[k] <= lane_d[k];
        end
    end

    always_comb begin
        cdb_wr = cdb_wr_q;
        for (int unsigned k = 0; k < N_CDB; k++) begin
            cdb_tag[k*TAG_W +: TAG_W]             = lane_q[k].tag;
            cdb_wdata[k*32 +: 32]                 = lane_q[k].wdata;
            cdb_inst_id[k*ROB_PTR_W +: ROB_PTR_W] = lane_q[k].inst_id;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a round-robin and an oldest-first instance
// share one stimulus stream and are checked against independent reference models.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [3:0]   rob_head;
    logic [3:0]   exu_req;
    logic [15:0]  exu_tag;
    logic [127:0] exu_wdata;
    logic [15:0]  exu_inst_id;

    logic [3:0]  rdy_rr, rdy_age;
    logic [1:0]  wr_rr, wr_age;
    logic [7:0]  tag_rr, tag_age;
    logic [63:0] wdata_rr, wdata_age;
    logic [7:0]  id_rr, id_age;

    typedef struct packed {
        logic [3:0]       rdy;
        logic [1:0]       wr;
        logic [1:0][3:0]  tag;
        logic [1:0][31:0] wdata;
        logic [1:0][3:0]  id;
    } exp_t;

    exp_t q_rr[$];
    exp_t q_age[$];
    int   rr_m;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .N_EXU(4), .N_CDB(2), .TAG_W(4), .ROB_DEPTH(16), .ARB_MODE(ARB_RR)
    ) dut_rr (
        .clk(clk), .rst_n(rst_n), .flush(flush), .rob_head(rob_head),
        .exu_req(exu_req), .exu_rdy(rdy_rr), .exu_tag(exu_tag),
        .exu_wdata(exu_wdata), .exu_inst_id(exu_inst_id),
        .cdb_wr(wr_rr), .cdb_tag(tag_rr), .cdb_wdata(wdata_rr), .cdb_inst_id(id_rr)
    );

    cdb_arbiter #(
        .N_EXU(4), .N_CDB(2), .TAG_W(4), .ROB_DEPTH(16), .ARB_MODE(ARB_AGE)
    ) dut_age (
        .clk(clk), .rst_n(rst_n), .flush(flush), .rob_head(rob_head),
        .exu_req(exu_req), .exu_rdy(rdy_age), .exu_tag(exu_tag),
        .exu_wdata(exu_wdata), .exu_inst_id(exu_inst_id),
        .cdb_wr(wr_age), .cdb_tag(tag_age), .cdb_wdata(wdata_age), .cdb_inst_id(id_age)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] age_of(input int i);
        logic [3:0] id;
        id = exu_inst_id[i*4 +: 4];
        return id - rob_head;
    endfunction

    function automatic exp_t model(input bit age_mode, input int rr, output int rr_nxt);
        exp_t       e;
        int         g[2];
        int         n;
        int         best;
        logic [3:0] left;
        e    = '0;
        n    = 0;
        left = flush ? 4'b0000 : exu_req;
        if (!age_mode) begin
            for (int off = 0; off < 4; off++) begin
                if (left[(rr + off) % 4] && n < 2) begin
                    g[n] = (rr + off) % 4;
                    n++;
                end
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                best = -1;
                for (int i = 0; i < 4; i++)
                    if (left[i] && (best < 0 || age_of(i) < age_of(best))) best = i;
                if (best >= 0) begin
                    g[n] = best;
                    n++;
                    left[best] = 1'b0;
                end
            end
        end
        for (int l = 0; l < n; l++) begin
            e.rdy[g[l]] = 1'b1;
            e.wr[l]     = 1'b1;
            e.tag[l]    = exu_tag[g[l]*4 +: 4];
            e.wdata[l]  = exu_wdata[g[l]*32 +: 32];
            e.id[l]     = exu_inst_id[g[l]*4 +: 4];
        end
        rr_nxt = age_mode ? 0 : (n > 0 ? (g[n-1] + 1) % 4 : rr);
        return e;
    endfunction

    task automatic cmp_lanes(input string who, input exp_t e, input logic [1:0] wr,
                             input logic [7:0] tag, input logic [63:0] wd, input logic [7:0] id);
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("%s_wr%0d", who, l), 64'(wr[l]), 64'(e.wr[l]));
            if (e.wr[l]) begin
                chk($sformatf("%s_tag%0d", who, l), 64'(tag[l*4 +: 4]), 64'(e.tag[l]));
                chk($sformatf("%s_wdata%0d", who, l), 64'(wd[l*32 +: 32]), 64'(e.wdata[l]));
                chk($sformatf("%s_id%0d", who, l), 64'(id[l*4 +: 4]), 64'(e.id[l]));
            end
        end
    endtask

    // Inputs must already be applied; samples rdy mid-cycle and lanes just after the edge.
    task automatic cycle();
        exp_t a, b;
        int   nx, dummy;
        a = model(1'b0, rr_m, nx);
        b = model(1'b1, 0, dummy);
        q_rr.push_back(a);
        q_age.push_back(b);
        #2;
        chk("rr_rdy", 64'(rdy_rr), 64'(a.rdy));
        chk("age_rdy", 64'(rdy_age), 64'(b.rdy));
        @(posedge clk);
        #1;
        rr_m = nx;
        cmp_lanes("rr", q_rr.pop_front(), wr_rr, tag_rr, wdata_rr, id_rr);
        cmp_lanes("age", q_age.pop_front(), wr_age, tag_age, wdata_age, id_age);
        chk("rr_ptr", 64'(dut_rr.rr_ptr_q), 64'(rr_m));
    endtask

    task automatic set_defaults();
        flush    = 1'b0;
        rob_head = 4'd0;
        for (int i = 0; i < 4; i++) begin
            exu_tag[i*4 +: 4]     = 4'(i);
            exu_wdata[i*32 +: 32] = 32'hDEAD_0000 + 32'(i);
            exu_inst_id[i*4 +: 4] = 4'(i);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rr_m    = 0;
        rst_n   = 1'b0;
        exu_req = 4'b1111;
        set_defaults();
        #3;
        chk("rst_rr_wr", 64'(wr_rr), 64'd0);
        chk("rst_rr_rdy", 64'(rdy_rr), 64'd0);
        chk("rst_age_rdy", 64'(rdy_age), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin sweep with all units requesting
        exu_req = 4'b1111;
        cycle();
        cycle();

        // Single request from exu2
        exu_req = 4'b0100;
        exu_tag[8 +: 4]     = 4'd5;
        exu_inst_id[8 +: 4] = 4'd7;
        exu_wdata[64 +: 32] = 32'h1234_5678;
        cycle();

        // Wrap from rr_ptr=3
        set_defaults();
        exu_req = 4'b1001;
        cycle();

        // Flush after a two-grant cycle
        exu_req = 4'b1111;
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();

        // Oldest-first with rob_head wrap
        rob_head    = 4'd14;
        exu_inst_id = {4'd3, 4'd14, 4'd1, 4'd15};
        exu_req     = 4'b1111;
        cycle();

        // Randomised traffic
        for (int n = 0; n < 200; n++) begin
            exu_req     = 4'($urandom);
            flush       = ($urandom_range(0, 7) == 0);
            rob_head    = 4'($urandom);
            exu_inst_id = 16'($urandom);
            exu_tag     = 16'($urandom);
            exu_wdata   = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end

        // Reset mid-traffic
        set_defaults();
        exu_req = 4'b1111;
        cycle();
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_rr_wr", 64'(wr_rr), 64'd0);
        chk("midrst_age_wr", 64'(wr_age), 64'd0);
        chk("midrst_rr_rdy", 64'(rdy_rr), 64'd0);
        chk("midrst_age_rdy", 64'(rdy_age), 64'd0);
        chk("midrst_rr_ptr", 64'(dut_rr.rr_ptr_q), 64'd0);
        q_rr.delete();
        q_age.delete();
        rr_m = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
